// File: rtl/mips32_run_ctrl_if.sv
// Host/core-side bus of the MIPS32 run controller: program stream, imem write port,
// CPU control/register read port and register-dump stream.
interface mips32_run_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              prog_valid;
  logic              prog_ready;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              cpu_clr;
  logic              cpu_run;
  logic              cpu_halted;
  logic [4:0]        reg_idx;
  logic [DATA_W-1:0] reg_data;

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [4:0]        dump_idx;

  // master = controller, slave = host bridge plus core
  modport master (
    input  prog_valid, prog_data, prog_last, cpu_halted, reg_data, dump_ready,
    output prog_ready, mem_we, mem_addr, mem_wdata, cpu_clr, cpu_run, reg_idx,
           dump_valid, dump_data, dump_idx
  );

  modport slave (
    output prog_valid, prog_data, prog_last, cpu_halted, reg_data, dump_ready,
    input  prog_ready, mem_we, mem_addr, mem_wdata, cpu_clr, cpu_run, reg_idx,
           dump_valid, dump_data, dump_idx
  );
endinterface

// File: rtl/mips32_run_ctrl.sv
// Program-load / run / register-dump controller for the PIPE_mips32 core.
// Optional RUN-cycle counter enabled by defining CYCLE_COUNT_EN.
module mips32_run_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int NDUMP  = 6,
  parameter int TMO_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  mips32_run_ctrl_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic                err_ovf,
  output logic                err_tmo,
  output logic [31:0]         cycle_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_RUN, S_DUMP} state_t;

  localparam logic [TMO_W-1:0] TMO_ONES  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_ONES - 1'b1;
  localparam logic [4:0]       DUMP_LAST = 5'(NDUMP - 1);

  state_t            state;
  logic [ADDR_W-1:0] waddr;
  logic [TMO_W-1:0]  tmo;
  logic              prog_ready_q, mem_we_q, cpu_clr_q, cpu_run_q, dvalid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, ddata_q;
  logic [4:0]        didx_q;

  logic xfer;
  assign xfer = bus.prog_valid && prog_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      waddr        <= '0;
      tmo          <= '0;
      prog_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_clr_q    <= 1'b0;
      cpu_run_q    <= 1'b0;
      dvalid_q     <= 1'b0;
      ddata_q      <= '0;
      didx_q       <= '0;
      done         <= 1'b0;
      err_ovf      <= 1'b0;
      err_tmo      <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      cpu_clr_q <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LOAD;
            prog_ready_q <= 1'b1;
            waddr        <= '0;
            err_ovf      <= 1'b0;
            err_tmo      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= waddr;
            mem_wdata_q <= bus.prog_data;
            waddr       <= waddr + 1'b1;
            if (bus.prog_last) begin
              state        <= S_CLR;
              prog_ready_q <= 1'b0;
              cpu_clr_q    <= 1'b1;
            end else if (waddr == '1) begin
              // the top word is still written; the next one would have nowhere to go
              state        <= S_IDLE;
              prog_ready_q <= 1'b0;
              err_ovf      <= 1'b1;
            end
          end
        end
        S_CLR: begin
          state     <= S_RUN;
          cpu_run_q <= 1'b1;
          tmo       <= '0;
          didx_q    <= '0;
          dvalid_q  <= 1'b0;
        end
        S_RUN: begin
          // tmo==0 marks the first RUN cycle, where HALTED may still be settling
          if (tmo != '0 && bus.cpu_halted) begin
            state     <= S_DUMP;
            cpu_run_q <= 1'b0;
          end else if (tmo == TMO_LAST) begin
            state     <= S_DUMP;
            cpu_run_q <= 1'b0;
            tmo       <= TMO_ONES;
            err_tmo   <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_DUMP: begin
          if (!dvalid_q) begin
            dvalid_q <= 1'b1;
            ddata_q  <= bus.reg_data;
          end else if (bus.dump_ready) begin
            dvalid_q <= 1'b0;
            if (didx_q == DUMP_LAST) begin
              state  <= S_IDLE;
              done   <= 1'b1;
              didx_q <= '0;
            end else begin
              didx_q <= didx_q + 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (state != S_IDLE);
  assign bus.prog_ready = prog_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_clr    = cpu_clr_q;
  assign bus.cpu_run    = cpu_run_q;
  assign bus.reg_idx    = didx_q;
  assign bus.dump_valid = dvalid_q;
  assign bus.dump_data  = ddata_q;
  assign bus.dump_idx   = didx_q;

`ifdef CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (state == S_CLR || (state == S_IDLE && start)) begin
      cyc_q <= '0;
    end else if (cpu_run_q && cyc_q != 32'hFFFF_FFFF) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Bench for mips32_run_ctrl: small instruction-level core model plus per-scenario checks.
module tb_mips32_run_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int NDUMP  = 6;
  localparam int TMO_W  = 6;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TMO_RUN = (1 << TMO_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err_ovf, err_tmo;
  logic [31:0] cycle_cnt;

  mips32_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips32_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NDUMP(NDUMP), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .err_ovf(err_ovf), .err_tmo(err_tmo), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // environment: instruction memory, register file and a one-instruction-per-cycle core
  logic [31:0] imem [DEPTH] = '{default: 32'h0};
  logic [31:0] rf [32] = '{default: 32'h0};
  logic [31:0] pc = 32'h0;
  logic halted = 1'b0;
  int wcount = 0, clr_cnt = 0, run_cnt = 0;

  wire [31:0] ir   = imem[pc[ADDR_W-1:0]];
  wire [5:0]  op   = ir[31:26];
  wire [4:0]  rs   = ir[25:21];
  wire [4:0]  rt   = ir[20:16];
  wire [4:0]  rd   = ir[15:11];
  wire [31:0] simm = {{16{ir[15]}}, ir[15:0]};

  assign bus.cpu_halted = halted;
  assign bus.reg_data   = rf[bus.reg_idx];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      imem[bus.mem_addr] <= bus.mem_wdata;
      wcount <= wcount + 1;
    end
    if (bus.cpu_clr) clr_cnt <= clr_cnt + 1;
  end

  always @(negedge clk) if (bus.cpu_run) run_cnt <= run_cnt + 1;

  always @(posedge clk) begin
    if (bus.cpu_clr) begin
      pc <= 32'h0;
      halted <= 1'b0;
    end else if (bus.cpu_run && !halted) begin
      pc <= pc + 32'd1;
      case (op)
        6'h00: if (rd != 5'd0) rf[rd] <= rf[rs] + rf[rt];
        6'h01: if (rd != 5'd0) rf[rd] <= rf[rs] - rf[rt];
        6'h02: if (rd != 5'd0) rf[rd] <= rf[rs] & rf[rt];
        6'h03: if (rd != 5'd0) rf[rd] <= rf[rs] | rf[rt];
        6'h0a: if (rt != 5'd0) rf[rt] <= rf[rs] + simm;
        6'h0e: if (rf[rs] == 32'h0) pc <= pc + 32'd1 + simm;
        6'h3f: halted <= 1'b1;
        default: ;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000ns");
    $fatal(1);
  end

  logic [31:0] prog [$];
  logic [31:0] exp_dump [NDUMP];
  logic [31:0] got_data [NDUMP];
  logic [4:0]  got_idx [NDUMP];
  int got_n, unstable;
  bit load_to, done1, done2, busy_after;

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load_prog(input bit rnd, input bit mark_last, input int start_at);
    int i = 0, cyc = 0;
    bit acc;
    load_to = 1'b0;
    while (i < prog.size() && cyc < 2000) begin
      @(negedge clk);
      bus.prog_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.prog_data  = prog[i];
      bus.prog_last  = mark_last && (i == prog.size() - 1);
      start = (cyc == start_at);
      acc = bus.prog_valid && bus.prog_ready;
      @(posedge clk);
      if (acc) i++;
      cyc++;
    end
    @(negedge clk);
    bus.prog_valid = 1'b0; bus.prog_last = 1'b0; start = 1'b0;
    if (i < prog.size()) load_to = 1'b1;
  endtask

  task automatic collect_dump(input bit rnd);
    int cyc = 0;
    bit hold = 1'b0;
    logic [31:0] hd = '0;
    logic [4:0]  hi = '0;
    got_n = 0; unstable = 0;
    for (int k = 0; k < NDUMP; k++) begin got_data[k] = '1; got_idx[k] = '1; end
    while (got_n < NDUMP && cyc < 1000) begin
      @(negedge clk);
      if (hold && (!bus.dump_valid || bus.dump_data !== hd || bus.dump_idx !== hi)) unstable++;
      bus.dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.dump_valid && bus.dump_ready) begin
        got_data[got_n] = bus.dump_data; got_idx[got_n] = bus.dump_idx;
        got_n++; hold = 1'b0;
      end else if (bus.dump_valid) begin
        hold = 1'b1; hd = bus.dump_data; hi = bus.dump_idx;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.dump_ready = 1'b0; done1 = done; busy_after = busy;
    @(negedge clk);
    done2 = done;
  endtask

  task automatic set_prog1();
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    exp_dump = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, done, err_ovf, err_tmo, bus.prog_ready, bus.mem_we, bus.cpu_clr, bus.cpu_run,
         bus.dump_valid} !== 9'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000000", {busy, done, err_ovf, err_tmo,
        bus.prog_ready, bus.mem_we, bus.cpu_clr, bus.cpu_run, bus.dump_valid});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.dump_data, bus.dump_idx, bus.reg_idx, cycle_cnt} !== '0) begin
      bad++; $display("FAIL reset_buses: got addr %h wdata %h dump %h idx %h cyc %h want all 0",
        bus.mem_addr, bus.mem_wdata, bus.dump_data, bus.dump_idx, cycle_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic(input bit rnd, input string nm);
    int w0, c0, r0, mm = 0;
    logic [31:0] exp_cc;
    set_prog1();
    w0 = wcount; c0 = clr_cnt; r0 = run_cnt;
    do_start();
    load_prog(rnd, 1'b1, rnd ? 3 : -1);
    collect_dump(rnd);
    for (int a = 0; a < prog.size(); a++) if (imem[a] !== prog[a]) mm++;
    total++; if (load_to || mm != 0) begin bad++; $display("FAIL %s_image: got %0d bad words timeout=%0d want 0", nm, mm, load_to); end
    total++; if (wcount - w0 != 9) begin bad++; $display("FAIL %s_writes: got %0d want 9", nm, wcount - w0); end
    total++; if (clr_cnt - c0 != 1) begin bad++; $display("FAIL %s_clr: got %0d want 1", nm, clr_cnt - c0); end
    total++; if (run_cnt - r0 != 10) begin bad++; $display("FAIL %s_run_cycles: got %0d want 10", nm, run_cnt - r0); end
    total++; if (got_n != NDUMP) begin bad++; $display("FAIL %s_dump_count: got %0d want %0d", nm, got_n, NDUMP); end
    for (int k = 0; k < NDUMP; k++) begin
      total++;
      if (got_data[k] !== exp_dump[k] || got_idx[k] !== 5'(k)) begin
        bad++; $display("FAIL %s_dump[%0d]: got idx %0d data %h want idx %0d data %h", nm, k, got_idx[k], got_data[k], k, exp_dump[k]);
      end
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL %s_dump_stable: got %0d changes want 0", nm, unstable); end
    total++; if ({done1, done2, busy_after, err_tmo, err_ovf} !== 5'b10000) begin
      bad++; $display("FAIL %s_done: got done %b,%b busy %b tmo %b ovf %b want 1,0 0 0 0", nm, done1, done2, busy_after, err_tmo, err_ovf);
    end
`ifdef CYCLE_COUNT_EN
    exp_cc = 32'(run_cnt - r0);
`else
    exp_cc = 32'd0;
`endif
    total++; if (cycle_cnt !== exp_cc) begin bad++; $display("FAIL %s_cycle_cnt: got %0d want %0d", nm, cycle_cnt, exp_cc); end
  endtask

  task automatic test_back_to_back();
    int w0, r0, mm = 0;
    logic [4:0] rt5;
    logic [15:0] imm16;
    prog.delete();
    exp_dump[0] = 32'd0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      rt5 = 5'(1 + j % 5);
      imm16 = 16'($urandom);
      prog.push_back({6'h0a, 5'd0, rt5, imm16});
      exp_dump[1 + j % 5] = {{16{imm16[15]}}, imm16};
    end
    prog.push_back(32'hfc000000);
    w0 = wcount; r0 = run_cnt;
    do_start();
    load_prog(1'b0, 1'b1, -1);
    collect_dump(1'b0);
    for (int a = 0; a < DEPTH; a++) if (imem[a] !== prog[a]) mm++;
    total++; if (load_to || mm != 0) begin bad++; $display("FAIL full_image: got %0d bad words want 0", mm); end
    total++; if (wcount - w0 != DEPTH) begin bad++; $display("FAIL full_writes: got %0d want %0d", wcount - w0, DEPTH); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL full_no_ovf: got %b want 0", err_ovf); end
    total++; if (run_cnt - r0 != DEPTH + 1) begin bad++; $display("FAIL full_run_cycles: got %0d want %0d", run_cnt - r0, DEPTH + 1); end
    for (int k = 0; k < NDUMP; k++) begin
      total++;
      if (got_data[k] !== exp_dump[k] || got_idx[k] !== 5'(k)) begin
        bad++; $display("FAIL full_dump[%0d]: got idx %0d data %h want idx %0d data %h", k, got_idx[k], got_data[k], k, exp_dump[k]);
      end
    end
    total++; if (done1 !== 1'b1 || busy_after !== 1'b0) begin bad++; $display("FAIL full_done: got done %b busy %b want 1 0", done1, busy_after); end
  endtask

  task automatic test_overflow();
    int w0, c0, r0, mm = 0;
    bit rdy_seen = 1'b0;
    prog.delete();
    for (int j = 0; j < DEPTH; j++) prog.push_back($urandom);
    w0 = wcount; c0 = clr_cnt; r0 = run_cnt;
    do_start();
    load_prog(1'b0, 1'b0, -1);
    total++; if ({err_ovf, busy, bus.prog_ready} !== 3'b100) begin
      bad++; $display("FAIL ovf_flags: got ovf %b busy %b ready %b want 1 0 0", err_ovf, busy, bus.prog_ready);
    end
    bus.prog_valid = 1'b1; bus.prog_data = 32'hdeadbeef; bus.prog_last = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.prog_ready) rdy_seen = 1'b1; end
    bus.prog_valid = 1'b0; bus.prog_last = 1'b0;
    for (int a = 0; a < DEPTH; a++) if (imem[a] !== prog[a]) mm++;
    total++; if (rdy_seen) begin bad++; $display("FAIL ovf_ready: got ready high after overflow want low"); end
    total++; if (load_to || mm != 0) begin bad++; $display("FAIL ovf_image: got %0d bad words want 0", mm); end
    total++; if (wcount - w0 != DEPTH) begin bad++; $display("FAIL ovf_writes: got %0d want %0d", wcount - w0, DEPTH); end
    total++; if (clr_cnt != c0 || run_cnt != r0) begin bad++; $display("FAIL ovf_no_run: got clr %0d run %0d want 0 0", clr_cnt - c0, run_cnt - r0); end
    total++; if (cycle_cnt !== 32'd0 || busy !== 1'b0) begin bad++; $display("FAIL ovf_idle: got cyc %0d busy %b want 0 0", cycle_cnt, busy); end
  endtask

  task automatic test_timeout();
    int r0, cyc = 0;
    logic [31:0] exp_cc;
    prog = '{32'h3800ffff};
    r0 = run_cnt;
    do_start();
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL tmo_ovf_cleared: got %b want 0", err_ovf); end
    load_prog(1'b0, 1'b1, -1);
    while (!bus.cpu_run && cyc < 20) begin @(negedge clk); cyc++; end
    total++; if (!bus.cpu_run) begin bad++; $display("FAIL tmo_run_start: got cpu_run 0 want 1"); end
    do_start();
    collect_dump(1'b1);
    total++; if (err_tmo !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", err_tmo); end
    total++; if (run_cnt - r0 != TMO_RUN) begin bad++; $display("FAIL tmo_run_cycles: got %0d want %0d", run_cnt - r0, TMO_RUN); end
    total++; if (got_n != NDUMP) begin bad++; $display("FAIL tmo_dump_count: got %0d want %0d", got_n, NDUMP); end
    for (int k = 0; k < NDUMP; k++) begin
      total++;
      if (got_data[k] !== exp_dump[k] || got_idx[k] !== 5'(k)) begin
        bad++; $display("FAIL tmo_dump[%0d]: got idx %0d data %h want idx %0d data %h", k, got_idx[k], got_data[k], k, exp_dump[k]);
      end
    end
    total++; if (unstable != 0 || done1 !== 1'b1) begin bad++; $display("FAIL tmo_dump_hs: got unstable %0d done %b want 0 1", unstable, done1); end
`ifdef CYCLE_COUNT_EN
    exp_cc = 32'(TMO_RUN);
`else
    exp_cc = 32'd0;
`endif
    total++; if (cycle_cnt !== exp_cc) begin bad++; $display("FAIL tmo_cycle_cnt: got %0d want %0d", cycle_cnt, exp_cc); end
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    set_prog1();
    do_start();
    load_prog(1'b0, 1'b1, -1);
    while (!bus.cpu_run && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    #2; rst_n = 1'b0; start = 1'b1;
    #1;
    total++; if ({bus.cpu_run, busy} !== 2'b00) begin bad++; $display("FAIL arst_immediate: got run %b busy %b want 0 0", bus.cpu_run, busy); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    total++; if ({busy, bus.prog_ready} !== 2'b00) begin bad++; $display("FAIL arst_start_dropped: got busy %b ready %b want 0 0", busy, bus.prog_ready); end
  endtask

  initial begin
    bus.prog_valid = 1'b0; bus.prog_data = '0; bus.prog_last = 1'b0; bus.dump_ready = 1'b0;
    test_reset();
    test_basic(1'b0, "basic");
    test_basic(1'b1, "backpressure");
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_async_reset();
    test_basic(1'b0, "after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
